// File: rtl/round_phase_sequencer_if.sv
// Phase-block handshake and shared memory write bus for round_phase_sequencer.
// master = sequencer side, slave = phase blocks plus memory.
interface round_phase_sequencer_if #(
    parameter int NUM_PHASES = 4
);
    logic [NUM_PHASES-1:0]    phase_done;
    logic [NUM_PHASES-1:0]    phase_wr_en;
    logic [NUM_PHASES*11-1:0] phase_address;
    logic [NUM_PHASES*16-1:0] phase_data;
    logic [NUM_PHASES-1:0]    phase_en;
    logic [NUM_PHASES-1:0]    phase_start;
    logic                     mem_wr_en;
    logic [10:0]              mem_address;
    logic [15:0]              mem_data;

    modport master (
        input  phase_done, phase_wr_en, phase_address, phase_data,
        output phase_en, phase_start, mem_wr_en, mem_address, mem_data
    );

    modport slave (
        output phase_done, phase_wr_en, phase_address, phase_data,
        input  phase_en, phase_start, mem_wr_en, mem_address, mem_data
    );
endinterface

// File: rtl/round_phase_sequencer.sv
// Per-round phase sequencer and owner of the shared memory write port.
// Optional WAIT watchdog enabled by defining ROUND_TIMEOUT_EN.
module round_phase_sequencer #(
    parameter int NUM_PHASES     = 4,
    parameter int PHASE_W        = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  round_start,
    round_phase_sequencer_if.master bus,
    output logic [PHASE_W-1:0]    cur_phase,
    output logic                  busy,
    output logic                  round_done,
    output logic [15:0]           round_count,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENABLE,
        S_START,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W-1:0] ONE  = PHASE_W'(1);

    state_t                  r_state;
    state_t                  w_next;
    logic [PHASE_W-1:0]      r_idx;
    logic [PHASE_W-1:0]      w_next_idx;
    logic [NUM_PHASES-1:0]   r_phase_en;
    logic [NUM_PHASES-1:0]   r_phase_start;
    logic [NUM_PHASES-1:0]   w_next_hot;
    logic                    r_busy;
    logic                    r_round_done;
    logic [15:0]             r_round_count;
    logic                    w_done_act;
    logic                    w_wr_act;
    logic [10:0]             w_addr_act;
    logic [15:0]             w_data_act;
    logic                    w_mem_act;
    logic                    w_wait_exp;

    // Select the active phase's slice without a narrow-index part-select.
    always_comb begin
        w_done_act = 1'b0;
        w_wr_act   = 1'b0;
        w_addr_act = '0;
        w_data_act = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (r_idx == PHASE_W'(i)) begin
                w_done_act = bus.phase_done[i];
                w_wr_act   = bus.phase_wr_en[i];
                w_addr_act = bus.phase_address[11*i +: 11];
                w_data_act = bus.phase_data[16*i +: 16];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (round_start) begin
                    w_next     = S_ENABLE;
                    w_next_idx = '0;
                end
            end
            S_ENABLE: w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_act) begin
                    if (r_idx == LAST) begin
                        w_next = S_FINISH;
                    end else begin
                        w_next     = S_ENABLE;
                        w_next_idx = r_idx + ONE;
                    end
                end else if (w_wait_exp) begin
                    w_next     = S_IDLE;
                    w_next_idx = '0;
                end
            end
            S_FINISH: begin
                w_next     = S_IDLE;
                w_next_idx = '0;
            end
            default: begin
                w_next     = S_IDLE;
                w_next_idx = '0;
            end
        endcase
    end

    always_comb begin
        w_next_hot = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_next_hot[i] = (w_next_idx == PHASE_W'(i));
        end
    end

    // Pulses are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_phase_en    <= '0;
            r_phase_start <= '0;
            r_busy        <= 1'b0;
            r_round_done  <= 1'b0;
            r_round_count <= '0;
        end else begin
            r_state       <= w_next;
            r_idx         <= w_next_idx;
            r_phase_en    <= (w_next == S_ENABLE) ? w_next_hot : '0;
            r_phase_start <= (w_next == S_START) ? w_next_hot : '0;
            r_busy        <= (w_next != S_IDLE);
            r_round_done  <= (r_state == S_FINISH);
            if (r_state == S_FINISH) begin
                r_round_count <= r_round_count + 16'd1;
            end
        end
    end

`ifdef ROUND_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_error;
    logic        w_timeout;

    assign w_wait_exp = (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_timeout  = (r_state == S_WAIT) && !w_done_act && w_wait_exp;

    // Counter sits at zero outside WAIT, so it starts clean on every entry.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_state == S_IDLE && round_start) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error = r_error;
`else
    assign w_wait_exp = 1'b0;
    assign error      = 1'b0;
`endif

    assign w_mem_act = (r_state == S_START) || (r_state == S_WAIT);

    assign bus.phase_en    = r_phase_en;
    assign bus.phase_start = r_phase_start;
    assign bus.mem_wr_en   = w_mem_act & w_wr_act;
    assign bus.mem_address = w_mem_act ? w_addr_act : '0;
    assign bus.mem_data    = w_mem_act ? w_data_act : '0;

    assign cur_phase   = r_idx;
    assign busy        = r_busy;
    assign round_done  = r_round_done;
    assign round_count = r_round_count;

endmodule

// File: tb/tb_round_phase_sequencer.sv
// Bench for round_phase_sequencer: round-level model plus directed checks.
// Timeout scenario runs only when ROUND_TIMEOUT_EN is defined.
module tb_round_phase_sequencer;

    localparam int N = 4;
    localparam int T = 10;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        round_start = 1'b0;
    logic [2:0]  cur_phase;
    logic        busy;
    logic        round_done;
    logic [15:0] round_count;
    logic        error;

    round_phase_sequencer_if #(.NUM_PHASES(N)) bus ();

    round_phase_sequencer #(
        .NUM_PHASES    (N),
        .PHASE_W       (3),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock      (clock),
        .nrst       (nrst),
        .round_start(round_start),
        .bus        (bus),
        .cur_phase  (cur_phase),
        .busy       (busy),
        .round_done (round_done),
        .round_count(round_count),
        .error      (error)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ts [N];
    int done_mode = 0;

    logic [N-1:0]    g_wr = '0;
    logic [N*11-1:0] g_ad = '0;
    logic [N*16-1:0] g_da = '0;

    // Round model: busy flag, active phase, cycles spent in that phase.
    bit m_busy = 0;
    bit m_fin  = 0;
    bit m_rd   = 0;
    bit m_err  = 0;
    int m_ph   = 0;
    int m_age  = 0;
    int m_cnt  = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_rd = 0; m_err = 0;
        m_ph = 0; m_age = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) ts[i] = -1;
    endtask

    task automatic compare();
        logic [N-1:0] e_en, e_st;
        logic         act;
        logic         e_wr;
        logic [10:0]  e_ad;
        logic [15:0]  e_da;
        e_en = '0;
        e_st = '0;
        if (m_busy && !m_fin && m_age == 0) e_en[m_ph] = 1'b1;
        if (m_busy && !m_fin && m_age == 1) e_st[m_ph] = 1'b1;
        act  = m_busy && !m_fin && m_age >= 1;
        e_wr = act ? g_wr[m_ph] : 1'b0;
        e_ad = act ? g_ad[m_ph*11 +: 11] : 11'h0;
        e_da = act ? g_da[m_ph*16 +: 16] : 16'h0;
        chk("phase_en", bus.phase_en, e_en);
        chk("phase_start", bus.phase_start, e_st);
        chk("mem_wr_en", bus.mem_wr_en, e_wr);
        chk("mem_address", bus.mem_address, e_ad);
        chk("mem_data", bus.mem_data, e_da);
        chk("cur_phase", cur_phase, m_busy ? m_ph : 0);
        chk("busy", busy, m_busy);
        chk("round_done", round_done, m_rd);
        chk("round_count", round_count, m_cnt);
        chk("error", error, m_err);
    endtask

    task automatic model_step(bit rs, logic [N-1:0] dn);
        bit nrd;
        nrd = m_fin;
        if (!m_busy) begin
            if (rs) begin
                m_busy = 1; m_ph = 0; m_age = 0; m_err = 0;
            end
        end else if (m_fin) begin
            m_fin = 0; m_busy = 0; m_ph = 0;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (m_age < 2) begin
            m_age++;
        end else if (dn[m_ph]) begin
            if (m_ph == N - 1) m_fin = 1;
            else begin
                m_ph++; m_age = 0;
            end
        end
`ifdef ROUND_TIMEOUT_EN
        else if (m_age - 1 == T) begin
            m_busy = 0; m_ph = 0; m_err = 1;
        end
`endif
        else begin
            m_age++;
        end
        m_rd = nrd;
    endtask

    // One cycle: phase blocks react, inputs driven, outputs compared.
    task automatic step(bit rs);
        logic [N-1:0] dn;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (bus.phase_en[i] === 1'b1) ts[i] = -1;
            if (bus.phase_start[i] === 1'b1) ts[i] = cyc;
            dn[i] = (ts[i] >= 0) && (cyc >= ts[i] + 3);
        end
        if (done_mode == 1) dn = '1;
        if (done_mode == 2) dn[1] = 1'b0;
        round_start       = rs;
        bus.phase_done    = dn;
        bus.phase_wr_en   = g_wr;
        bus.phase_address = g_ad;
        bus.phase_data    = g_da;
        #1;
        compare();
        model_step(rs, dn);
        cyc++;
    endtask

    initial begin
        bus.phase_done    = '0;
        bus.phase_wr_en   = '0;
        bus.phase_address = '0;
        bus.phase_data    = '0;
        model_reset();

        // Reset state
        step(0);
        step(0);
        chk("rst_busy", busy, 0);
        chk("rst_count", round_count, 0);
        chk("rst_en", bus.phase_en, 0);
        nrst = 1'b1;
        step(0);

        // Normal round with fixed write pattern
        g_wr = 4'b1010;
        g_ad = {11'h7, 11'h9, 11'h2, 11'h5};
        g_da = {16'hCCCC, 16'hBBBB, 16'h0001, 16'hAAAA};
        for (int k = 0; k <= 24; k++) begin
            step(k == 0);
            if (k == 1) chk("n_en0", bus.phase_en, 4'b0001);
            if (k == 2) chk("n_st0", bus.phase_start, 4'b0001);
            if (k == 6) chk("n_en1", bus.phase_en, 4'b0010);
            if (k == 6) chk("n_en1_wr", bus.mem_wr_en, 0);
            if (k == 7) chk("arb_addr", bus.mem_address, 11'h2);
            if (k == 7) chk("arb_data", bus.mem_data, 16'h1);
            if (k == 9) chk("arb_wr", bus.mem_wr_en, 1);
            if (k == 16) chk("n_en3", bus.phase_en, 4'b1000);
            if (k == 21) chk("n_fin_busy", busy, 1);
            if (k == 22) chk("n_rdone", round_done, 1);
            if (k == 22) chk("n_count", round_count, 1);
            if (k == 23) chk("n_rdone_off", round_done, 0);
        end

        // Stale done held high across the round
        done_mode = 1;
        for (int k = 0; k <= 16; k++) begin
            g_wr = 4'($urandom);
            g_ad = 44'({$urandom, $urandom});
            g_da = 64'({$urandom, $urandom});
            step(k == 0);
            if (k == 2) chk("s_st0", bus.phase_start, 4'b0001);
            if (k == 4) chk("s_en1", bus.phase_en, 4'b0010);
            if (k == 14) chk("s_rdone", round_done, 1);
            if (k == 14) chk("s_count", round_count, 2);
        end
        done_mode = 0;

        // round_start during phase 2 WAIT is dropped
        for (int k = 0; k <= 27; k++) begin
            step(k == 0 || k == 13);
            if (k == 13) chk("b_phase", cur_phase, 2);
            if (k == 22) chk("b_count", round_count, 3);
            if (k == 27) chk("b_idle", busy, 0);
            if (k == 27) chk("b_count2", round_count, 3);
        end

        // Asynchronous reset during phase 2 WAIT
        for (int k = 0; k <= 13; k++) step(k == 0);
        nrst = 1'b0;
        #1;
        chk("r_en", bus.phase_en, 0);
        chk("r_st", bus.phase_start, 0);
        chk("r_wr", bus.mem_wr_en, 0);
        chk("r_addr", bus.mem_address, 0);
        chk("r_data", bus.mem_data, 0);
        chk("r_phase", cur_phase, 0);
        chk("r_busy", busy, 0);
        chk("r_rdone", round_done, 0);
        chk("r_count", round_count, 0);
        chk("r_err", error, 0);
        model_reset();
        step(0);
        step(0);
        nrst = 1'b1;
        for (int k = 0; k < 5; k++) step(0);
        chk("r_after_idle", busy, 0);
        for (int k = 0; k <= 22; k++) begin
            step(k == 0);
            if (k == 22) chk("r_recount", round_count, 1);
        end

`ifdef ROUND_TIMEOUT_EN
        // Phase 1 never finishes: watchdog returns to IDLE
        done_mode = 2;
        for (int k = 0; k <= 20; k++) begin
            step(k == 0);
            if (k == 17) chk("t_busy17", busy, 1);
            if (k == 18) chk("t_err", error, 1);
            if (k == 18) chk("t_busy", busy, 0);
            if (k == 18) chk("t_count", round_count, 1);
        end
        done_mode = 0;
        for (int k = 0; k <= 22; k++) begin
            step(k == 0);
            if (k == 1) chk("t_err_clr", error, 0);
            if (k == 22) chk("t_count2", round_count, 2);
        end
`endif

        step(0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
